// File: rtl/vdp_pkg.sv
// Shared definitions for the nouveau-vdp99 CPU port: address width, port mode
// encodings, second control byte command codes and the VRAM request FSM states.
package vdp_pkg;

    localparam int VRAM_ADDR_W = 14;

    localparam logic MODE_DATA = 1'b0;
    localparam logic MODE_CTRL = 1'b1;

    // Command field is cpu_din[7:6] of the second control byte.
    // Register writes only look at the MSB; the low bit is a don't-care.
    localparam logic [1:0] CMD_RD_SETUP = 2'b00;
    localparam logic [1:0] CMD_WR_SETUP = 2'b01;
    localparam logic [1:0] CMD_REG      = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WR_REQ  = 2'd1,
        ST_RD_REQ  = 2'd2,
        ST_RD_DATA = 2'd3
    } vram_state_e;

    // True when the second control byte selects a register write (2'b1x).
    function automatic logic is_reg_cmd(input logic [1:0] cmd);
        return cmd[1] == CMD_REG[1];
    endfunction

endpackage

// File: rtl/vdp_vram_req.sv
// VRAM request engine: owns the auto-incrementing address, the write data
// register and the read-ahead buffer, and runs the single-byte handshake
// with the arbiter. Starts are only honoured in IDLE.
module vdp_vram_req
    import vdp_pkg::*;
#(
    parameter int ADDR_W = VRAM_ADDR_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start_wr,
    input  logic              start_rd,
    input  logic              set_addr,
    input  logic [ADDR_W-1:0] new_addr,
    input  logic [7:0]        wdata_in,
    input  logic              vram_ack,
    input  logic [7:0]        vram_rdata,
    output logic              vram_req,
    output logic              vram_we,
    output logic [ADDR_W-1:0] vram_addr,
    output logic [7:0]        vram_wdata,
    output logic [7:0]        rd_buf,
    output logic              busy
);

    vram_state_e       state_q, state_d;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        wdata_q, wdata_d;
    logic [7:0]        buf_q, buf_d;

    // Next-state logic for the handshake FSM and its datapath registers.
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        buf_d   = buf_q;
        case (state_q)
            ST_IDLE: begin
                if (set_addr) begin
                    addr_d = new_addr;
                end
                if (start_wr) begin
                    state_d = ST_WR_REQ;
                    req_d   = 1'b1;
                    we_d    = 1'b1;
                    wdata_d = wdata_in;
                end else if (start_rd) begin
                    state_d = ST_RD_REQ;
                    req_d   = 1'b1;
                    we_d    = 1'b0;
                end
            end
            ST_WR_REQ: begin
                if (vram_ack) begin
                    state_d = ST_IDLE;
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    addr_d  = addr_q + ADDR_W'(1);
                end
            end
            ST_RD_REQ: begin
                if (vram_ack) begin
                    state_d = ST_RD_DATA;
                    req_d   = 1'b0;
                end
            end
            ST_RD_DATA: begin
                // sysMEM read is registered: data arrives the cycle after ack.
                state_d = ST_IDLE;
                buf_d   = vram_rdata;
                addr_d  = addr_q + ADDR_W'(1);
            end
            default: begin
                state_d = ST_IDLE;
                req_d   = 1'b0;
                we_d    = 1'b0;
            end
        endcase
    end

    // FSM and datapath registers; reset aborts any outstanding request at once.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 8'h00;
            buf_q   <= 8'h00;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            buf_q   <= buf_d;
        end
    end

    assign vram_req   = req_q;
    assign vram_we    = we_q;
    assign vram_addr  = addr_q;
    assign vram_wdata = wdata_q;
    assign rd_buf     = buf_q;
    assign busy       = (state_q != ST_IDLE);

endmodule

// File: rtl/vdp_cpu_port.sv
// TMS9918-style CPU port for the nouveau-vdp99 VDP. Decodes data/control port
// strobes into register writes, status reads, address setup and VRAM requests.
// Optional build macro VDP_CPU_WAIT_EN: adds cpu_wait and a one-entry pending
// slot so accesses arriving while busy are deferred instead of dropped.
module vdp_cpu_port
    import vdp_pkg::*;
#(
    parameter int ADDR_W = VRAM_ADDR_W,
    parameter int REG_N  = 8,
    localparam int REG_W = $clog2(REG_N)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cpu_wr,
    input  logic              cpu_rd,
    input  logic              cpu_mode,
    input  logic [7:0]        cpu_din,
    output logic [7:0]        cpu_dout,
    input  logic [7:0]        status_in,
    output logic              status_rd,
    output logic              reg_we,
    output logic [REG_W-1:0]  reg_num,
    output logic [7:0]        reg_data,
    output logic              vram_req,
    output logic              vram_we,
    output logic [ADDR_W-1:0] vram_addr,
    output logic [7:0]        vram_wdata,
    input  logic              vram_ack,
    input  logic [7:0]        vram_rdata,
`ifdef VDP_CPU_WAIT_EN
    output logic              cpu_wait,
`endif
    output logic              busy,
    output logic              overrun
);

    logic              busy_w;
    logic [7:0]        rd_buf;
    logic              start_wr, start_rd, set_addr, drop;
    logic [ADDR_W-1:0] new_addr;

    logic              acc_wr, acc_rd, acc_mode;
    logic [7:0]        acc_din;

    logic [7:0]        latch_q, latch_d;
    logic              flag_q, flag_d;
    logic [7:0]        cpu_dout_q, cpu_dout_d;
    logic              status_rd_q, status_rd_d;
    logic              reg_we_q, reg_we_d;
    logic [REG_W-1:0]  reg_num_q, reg_num_d;
    logic [7:0]        reg_data_q, reg_data_d;

`ifdef VDP_CPU_WAIT_EN
    logic              pend_valid_q, pend_valid_d;
    logic              pend_wr_q, pend_wr_d;
    logic              pend_mode_q, pend_mode_d;
    logic [7:0]        pend_din_q, pend_din_d;
`else
    logic              overrun_q, overrun_d;
`endif

    // Select the access to decode this cycle: a live strobe (write beats read),
    // or the deferred access once the engine has returned to IDLE.
    always_comb begin
        acc_wr   = cpu_wr;
        acc_rd   = cpu_rd & ~cpu_wr;
        acc_mode = cpu_mode;
        acc_din  = cpu_din;
`ifdef VDP_CPU_WAIT_EN
        // While the slot is occupied the CPU is being held off, so live
        // strobes are not considered.
        if (pend_valid_q) begin
            acc_wr   = !busy_w && pend_wr_q;
            acc_rd   = !busy_w && !pend_wr_q;
            acc_mode = pend_mode_q;
            acc_din  = pend_din_q;
        end
`endif
    end

    // CPU protocol decode: two-byte control sequence, data port and status port.
    always_comb begin
        latch_d     = latch_q;
        flag_d      = flag_q;
        cpu_dout_d  = cpu_dout_q;
        status_rd_d = 1'b0;
        reg_we_d    = 1'b0;
        reg_num_d   = reg_num_q;
        reg_data_d  = reg_data_q;
        start_wr    = 1'b0;
        start_rd    = 1'b0;
        set_addr    = 1'b0;
        drop        = 1'b0;
        new_addr    = ADDR_W'({acc_din[5:0], latch_q});
`ifdef VDP_CPU_WAIT_EN
        pend_valid_d = pend_valid_q;
        pend_wr_d    = pend_wr_q;
        pend_mode_d  = pend_mode_q;
        pend_din_d   = pend_din_q;
`else
        overrun_d    = overrun_q;
`endif
        if (acc_wr) begin
            if (acc_mode == MODE_CTRL) begin
                if (!flag_q) begin
                    latch_d = acc_din;
                    flag_d  = 1'b1;
                end else if (is_reg_cmd(acc_din[7:6])) begin
                    flag_d     = 1'b0;
                    reg_we_d   = 1'b1;
                    reg_num_d  = acc_din[REG_W-1:0];
                    reg_data_d = latch_q;
                end else if (busy_w) begin
                    // The address register belongs to the outstanding request.
                    drop = 1'b1;
                end else begin
                    flag_d   = 1'b0;
                    set_addr = 1'b1;
                    start_rd = (acc_din[7:6] == CMD_RD_SETUP);
                end
            end else if (busy_w) begin
                drop = 1'b1;
            end else begin
                flag_d   = 1'b0;
                start_wr = 1'b1;
            end
        end else if (acc_rd) begin
            if (acc_mode == MODE_CTRL) begin
                cpu_dout_d  = status_in;
                status_rd_d = 1'b1;
                flag_d      = 1'b0;
            end else if (busy_w) begin
                drop = 1'b1;
            end else begin
                // Return the read-ahead byte and refill it from the next address.
                cpu_dout_d = rd_buf;
                start_rd   = 1'b1;
                flag_d     = 1'b0;
            end
        end
`ifdef VDP_CPU_WAIT_EN
        if (pend_valid_q && !busy_w) begin
            pend_valid_d = 1'b0;
        end
        if (drop && !pend_valid_q) begin
            pend_valid_d = 1'b1;
            pend_wr_d    = acc_wr;
            pend_mode_d  = acc_mode;
            pend_din_d   = acc_din;
        end
`else
        if (drop || (cpu_wr && cpu_rd)) begin
            overrun_d = 1'b1;
        end
`endif
    end

    // Protocol registers and registered CPU-side outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            latch_q      <= 8'h00;
            flag_q       <= 1'b0;
            cpu_dout_q   <= 8'h00;
            status_rd_q  <= 1'b0;
            reg_we_q     <= 1'b0;
            reg_num_q    <= '0;
            reg_data_q   <= 8'h00;
`ifdef VDP_CPU_WAIT_EN
            pend_valid_q <= 1'b0;
            pend_wr_q    <= 1'b0;
            pend_mode_q  <= 1'b0;
            pend_din_q   <= 8'h00;
`else
            overrun_q    <= 1'b0;
`endif
        end else begin
            latch_q      <= latch_d;
            flag_q       <= flag_d;
            cpu_dout_q   <= cpu_dout_d;
            status_rd_q  <= status_rd_d;
            reg_we_q     <= reg_we_d;
            reg_num_q    <= reg_num_d;
            reg_data_q   <= reg_data_d;
`ifdef VDP_CPU_WAIT_EN
            pend_valid_q <= pend_valid_d;
            pend_wr_q    <= pend_wr_d;
            pend_mode_q  <= pend_mode_d;
            pend_din_q   <= pend_din_d;
`else
            overrun_q    <= overrun_d;
`endif
        end
    end

    vdp_vram_req #(
        .ADDR_W (ADDR_W)
    ) u_vram_req (
        .clk        (clk),
        .reset_n    (reset_n),
        .start_wr   (start_wr),
        .start_rd   (start_rd),
        .set_addr   (set_addr),
        .new_addr   (new_addr),
        .wdata_in   (acc_din),
        .vram_ack   (vram_ack),
        .vram_rdata (vram_rdata),
        .vram_req   (vram_req),
        .vram_we    (vram_we),
        .vram_addr  (vram_addr),
        .vram_wdata (vram_wdata),
        .rd_buf     (rd_buf),
        .busy       (busy_w)
    );

    assign cpu_dout  = cpu_dout_q;
    assign status_rd = status_rd_q;
    assign reg_we    = reg_we_q;
    assign reg_num   = reg_num_q;
    assign reg_data  = reg_data_q;
    assign busy      = busy_w;
`ifdef VDP_CPU_WAIT_EN
    assign cpu_wait  = busy_w | pend_valid_q;
    assign overrun   = 1'b0;
`else
    assign overrun   = overrun_q;
`endif

endmodule

// File: doc/vdp_cpu_port.md
Name: vdp_cpu_port

Overview:
- CPU-side VRAM writer/reader for the nouveau-vdp99 VDP.
- Implements the TMS9918-style two-port protocol:
  - mode 0 = VRAM data port.
  - mode 1 = control port, used for address setup, register writes and status reads.
- Issues single-byte requests to the VRAM arbiter that fronts the sysMEM block.
- Owns the auto-incrementing VRAM address and the read-ahead buffer.

Parameters:
- ADDR_W, 14, VRAM address width (16 KiB).
- REG_N, 8, number of VDP write-only registers; the register index width is clog2(REG_N).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- cpu_wr  in  1  one-cycle write strobe, already synchronised to clk.
- cpu_rd  in  1  one-cycle read strobe, already synchronised to clk.
- cpu_mode  in  1  0 = data port, 1 = control port.
- cpu_din  in  8  CPU write data.
- cpu_dout  out  8  CPU read data; valid from the cycle after cpu_rd until the next cpu_rd.
- status_in  in  8  status byte supplied by the display engine.
- status_rd  out  1  one-cycle pulse in the cycle after a control-port read.
- reg_we  out  1  one-cycle register-write pulse.
- reg_num  out  3  register index.
- reg_data  out  8  register value.
- vram_req  out  1  request to the arbiter; held until vram_ack.
- vram_we  out  1  1 = write request, 0 = read request; stable while vram_req is high.
- vram_addr  out  ADDR_W  request address.
- vram_wdata  out  8  write data.
- vram_ack  in  1  arbiter grant; address and data are sampled in this cycle.
- vram_rdata  in  8  read data, valid exactly 1 cycle after an ack for a read (registered sysMEM read).
- busy  out  1  a request is outstanding.
- overrun  out  1  sticky: a CPU access was dropped.

Behaviour:
- Reset values: all outputs 0; addr = 0; first-byte flag = 0; read-ahead buffer = 0x00; FSM in IDLE.
- Reset asserted mid-request aborts it immediately. Any arbiter ack arriving after reset is ignored.
- FSM states:
  - IDLE: no request outstanding.
  - WR_REQ: vram_req=1, vram_we=1. On vram_ack: addr <= addr+1, go to IDLE.
  - RD_REQ: vram_req=1, vram_we=0. On vram_ack: go to RD_DATA.
  - RD_DATA: buffer <= vram_rdata, addr <= addr+1, go to IDLE.
- busy = (state != IDLE).
- Address arithmetic is modulo 2^ADDR_W; 0x3FFF increments to 0x0000.
- Control write, first byte (flag=0): latch <= cpu_din, flag <= 1. This is accepted even when busy.
- Control write, second byte (flag=1): flag <= 0, then:
  - cpu_din[7]=1: register write. reg_we pulses the next cycle with reg_num=cpu_din[2:0] and reg_data=latch. addr is unchanged.
  - cpu_din[7:6]=01: addr <= {cpu_din[5:0], latch}. No prefetch.
  - cpu_din[7:6]=00: addr <= {cpu_din[5:0], latch}, then enter RD_REQ (prefetch).
- Data write: vram_wdata <= cpu_din, enter WR_REQ, flag <= 0.
- Data read: cpu_dout <= buffer (the old value), enter RD_REQ, flag <= 0. Latency: from cpu_rd to buffer refreshed is ≥3 cycles; exactly 3 when ack is immediate.
- Control read: cpu_dout <= status_in, status_rd pulses, flag <= 0.
- cpu_wr and cpu_rd asserted together: the write wins, the read is ignored, and overrun is set.
- A data access, or a second-byte control write that would issue a request, while busy is dropped entirely (no state change, including addr) and overrun <= 1. Register writes and status reads are never dropped.
- overrun clears only on reset.

Optional Feature:
- Macro: VDP_CPU_WAIT_EN.
- Defined:
  - Adds output cpu_wait (1 bit) = busy OR a pending strobe.
  - Accesses that arrive while busy are held in a one-entry pending slot and issued on return to IDLE, so none are dropped.
  - overrun is tied to 0.
- Undefined: no cpu_wait port; the drop/overrun behaviour above applies.

Decomposition:
- Shared package vdp_pkg:
  - VRAM_ADDR_W = 14.
  - Mode encodings MODE_DATA = 0 and MODE_CTRL = 1.
  - Second-byte command codes CMD_RD_SETUP = 2'b00, CMD_WR_SETUP = 2'b01, CMD_REG = 2'b1x.
  - FSM state typedef.
- One natural sub-module: vdp_vram_req, containing the FSM, the request handshake, and the addr/buffer registers. The top level decodes the CPU protocol.

Test Plan:
1. Ctrl writes 0x34 then 0x52, data write 0xA5, ack after 2 cycles -> vram_addr=0x1234, vram_wdata=0xA5, vram_we=1; addr becomes 0x1235 after ack.
2. Ctrl writes 0x00 then 0x20, then two data reads with memory holding [0x2000]=0x11 and [0x2001]=0x22 -> first read returns 0x11 (prefetched), second returns 0x22; addr ends at 0x2003.
3. Ctrl writes 0x07 then 0x81 -> reg_we pulses once with reg_num=1, reg_data=0x07; no vram_req; addr unchanged.
4. Set addr 0x3FFF for write (0xFF, 0x7F), then write twice -> addresses 0x3FFF then 0x0000.
5. Data write while vram_ack is held low, then a second data write -> the second is dropped, overrun=1, a single WR request is issued. With VDP_CPU_WAIT_EN: cpu_wait=1 and both writes land at consecutive addresses.
6. First ctrl byte 0x55, then a control read (status_in=0x80) -> cpu_dout=0x80, status_rd pulses, flag cleared. A following ctrl write of 0x10 is treated as a first byte. Also: assert reset_n=0 during RD_REQ -> vram_req=0 in the same cycle, addr=0.
